// File: rtl/ddc_serial_tx.sv
// ddc_serial_tx: converter-side emulator for the DVALID_BAR / DXMIT_BAR / DOUT
// serial readout link. It buffers one parallel word and, on each conversion
// tick, announces it with DVALID_BAR and shifts it out LSB-first on request.
module ddc_serial_tx #(
  parameter int BITNUM      = 40,
  parameter int CONV_PERIOD = 1000,
  parameter int TIMEOUT     = 255,
  parameter int GAP         = 2
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [BITNUM-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              DVALID_BAR,
  input  logic              DXMIT_BAR,
  output logic              DOUT,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [7:0]        overrun_cnt
);

  localparam int PW = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
  localparam int IW = (BITNUM > 1) ? $clog2(BITNUM) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     period_cnt_q, period_cnt_d;
  logic [BITNUM-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BITNUM-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              dvalid_bar_q, dvalid_bar_d;
  logic              dout_q, dout_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              proto_err_q, proto_err_d;
  logic [7:0]        overrun_q, overrun_d;

  logic tick;
  logic start_frame;
  logic advance;
  logic last_bit;
  logic wait_expire;
  logic abort;

  assign tick = enable && (period_cnt_q == PW'(CONV_PERIOD - 1));

  // Register every piece of state; reset wins over any frame in progress.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      dvalid_bar_q  <= 1'b1;
      dout_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      dvalid_bar_q  <= dvalid_bar_d;
      dout_q        <= dout_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Decide the next protocol state and flag which transition is being taken.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    advance     = 1'b0;
    last_bit    = 1'b0;
    wait_expire = 1'b0;
    abort       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && hold_full_q) begin
          start_frame = 1'b1;
          state_d     = S_VALID;
        end
      end
      S_VALID: begin
        if (!DXMIT_BAR) begin
          advance = 1'b1;
          state_d = S_SHIFT;
        end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
          wait_expire = 1'b1;
          state_d     = S_GAP;
        end
      end
      S_SHIFT: begin
        if (DXMIT_BAR) begin
          abort   = 1'b1;
          state_d = S_GAP;
        end else if (bit_idx_q == IW'(BITNUM - 1)) begin
          last_bit = 1'b1;
          state_d  = S_GAP;
        end else begin
          advance = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Update the datapath, line outputs and status pulses for the chosen transition.
  always_comb begin
    period_cnt_d  = period_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shreg_d       = shreg_q;
    bit_idx_d     = bit_idx_q;
    wait_cnt_d    = wait_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    dvalid_bar_d  = dvalid_bar_q;
    dout_d        = dout_q;
    frame_done_d  = last_bit;
    timeout_err_d = wait_expire;
    proto_err_d   = abort;
    overrun_d     = overrun_q;

    if (!enable || tick) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + 1'b1;
    end

    if (din_valid && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (start_frame) begin
      shreg_d      = hold_q;
      hold_full_d  = 1'b0;
      bit_idx_d    = '0;
      wait_cnt_d   = '0;
      dvalid_bar_d = 1'b0;
      dout_d       = hold_q[0];
    end

    if ((state_q == S_VALID) && DXMIT_BAR) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (advance) begin
      bit_idx_d = bit_idx_q + 1'b1;
      shreg_d   = shreg_q >> 1;
      dout_d    = shreg_q[1];
    end

    if (last_bit || abort || wait_expire) begin
      dvalid_bar_d = 1'b1;
      dout_d       = 1'b0;
      gap_cnt_d    = '0;
    end

    if (state_q == S_GAP) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end

    if (tick && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  assign din_ready   = !hold_full_q;
  assign busy        = (state_q != S_IDLE);
  assign DVALID_BAR  = dvalid_bar_q;
  assign DOUT        = dout_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign proto_err   = proto_err_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: doc/ddc_serial_tx.md
Name: ddc_serial_tx

Overview:
- Converter-side transmitter for the DVALID_BAR / DXMIT_BAR / DOUT serial readout interface; the other end of the FPGA-side readout receiver.
- Takes parallel conversion words from a host/pattern source and presents them as periodic "conversions": asserts DVALID_BAR, waits for DXMIT_BAR, then shifts BITNUM bits LSB-first on DOUT.
- Used as a front-end emulator for loopback and self-test of the readout chain without the analog converter fitted.

Parameters:
- BITNUM, 40, bits per frame; DOUT order is bit 0 first.
- CONV_PERIOD, 1000, SYS_CLK cycles between conversion ticks; must be at least BITNUM+GAP+8.
- TIMEOUT, 255, maximum cycles in VALID waiting for DXMIT_BAR low.
- GAP, 2, minimum cycles DVALID_BAR is held high after a frame ends or aborts (must be at least 1).

Ports:
- SYS_CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- enable  in  1  runs the conversion-period counter; when low, counter held at 0 and no new ticks.
- din  in  BITNUM  word to transmit.
- din_valid  in  1  din is offered.
- din_ready  out  1  holding register empty (= !hold_full).
- DVALID_BAR  out  1  active-low "data ready" to the receiver.
- DXMIT_BAR  in  1  active-low transmit request from the receiver.
- DOUT  out  1  serial data.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last bit is consumed.
- timeout_err  out  1  one-cycle pulse on VALID timeout.
- proto_err  out  1  one-cycle pulse when DXMIT_BAR rises mid-frame.
- overrun_cnt  out  8  count of ticks lost (saturating).

Behaviour:
- Reset: synchronous; every output and register is forced on the SYS_CLK edge where RST=1, overriding all other activity including a frame in progress.
  - Reset values: DVALID_BAR=1, DOUT=0, din_ready=1, busy=0, all pulses 0, overrun_cnt=0, state=IDLE, period counter=0, hold_full=0, bit index=0.
- Holding register:
  - Load on the edge where din_valid & din_ready; hold_full<=1.
  - hold_full is cleared only by a transfer to the shift register.
- Tick: period counter counts 0..CONV_PERIOD-1 while enable=1; tick=1 on the cycle the counter equals CONV_PERIOD-1, then it wraps to 0.
- State IDLE:
  - On tick with hold_full=1: shreg<=hold, hold_full<=0, bit index<=0, DVALID_BAR<=0, DOUT<=hold[0], go to VALID, wait counter<=0.
  - On tick with hold_full=0: nothing; this is not an overrun.
- State VALID (DVALID_BAR=0, DOUT=shreg[0]):
  - If DXMIT_BAR==0 is sampled: bit index<=1, DOUT<=shreg[1], go to SHIFT.
  - Otherwise the wait counter increments. When it reaches TIMEOUT: DVALID_BAR<=1, DOUT<=0, timeout_err pulse, frame discarded, go to GAP.
- State SHIFT, on each edge:
  - If DXMIT_BAR==0 and bit index < BITNUM-1: index++, DOUT<=shreg[index+1].
  - If DXMIT_BAR==0 and bit index == BITNUM-1 (last bit was on DOUT this cycle): DVALID_BAR<=1, DOUT<=0, frame_done pulse, go to GAP.
  - If DXMIT_BAR==1 before the last bit: DVALID_BAR<=1, DOUT<=0, proto_err pulse, go to GAP.
- Timing consequence: bit k is on DOUT during the cycle after the k-th edge at which DXMIT_BAR was sampled low (bit 0 before the first). A receiver that drops DXMIT_BAR one cycle after seeing DVALID_BAR fall and samples DOUT on each following edge gets bits 0..BITNUM-1 in order.
- State GAP: DVALID_BAR=1; count GAP cycles, then go to IDLE. This guarantees a fresh DVALID_BAR falling edge for the next frame.
- Overrun: a tick while state != IDLE increments overrun_cnt, saturating at 255. That tick is lost; the next tick is taken.
- din acceptance is independent of state; a load may coincide with a tick. The tick uses registered hold_full, so a word loaded on the tick edge waits for the next tick.
- enable deasserted mid-frame does not abort the frame.

Test Plan:
- Basic frame: load din=40'hA5_1234_5678, enable=1, receiver model (DXMIT_BAR low 1 cycle after DVALID_BAR falls, 40 samples) -> received word 40'hA5_1234_5678; frame_done one pulse; DVALID_BAR low for exactly 41 cycles; din_ready high again on the tick edge.
- Back-to-back: 3 words loaded one per period (0x1, 0xFF_FFFF_FFFF, 0x80_0000_0001) -> all 3 received in order; DVALID_BAR high for ≥ GAP cycles between frames; overrun_cnt=0.
- Timeout: DXMIT_BAR held high -> after 255 wait cycles DVALID_BAR rises, timeout_err pulses once; next tick with a new word transmits normally.
- Protocol abort: DXMIT_BAR raised after 10 bits -> proto_err pulse, DVALID_BAR=1 the next cycle, state returns to IDLE after GAP.
- Overrun/saturation: CONV_PERIOD=50, receiver never responds, TIMEOUT=255 -> overrun_cnt increments per lost tick and sticks at 255.
- Reset mid-frame: assert RST at bit 20 -> next edge DVALID_BAR=1, DOUT=0, din_ready=1, overrun_cnt=0; the following frame is clean.
